// File: rtl/vga_circle_ctrl.sv
// vga_circle_ctrl
// ---------------------------------------------------------------------------
// Frame-synchronous animation controller for the VGA circle renderer.
// Once per FRAME_DIV vsync rising edges it recomputes the circle's radius
// (from latched grow/shrink key requests), its center (constant-speed bounce
// inside the active area) and its fill color (next palette entry on any
// wall bounce). New values are built in shadow registers and committed in a
// single cycle, so the pixel generator never sees a mixed parameter set.
//
// Ports
//   clk        in   1   system/pixel clock
//   rst_n      in   1   synchronous active-low reset
//   vsync      in   1   vertical sync from the timing generator (high = pulse)
//   run        in   1   1 = motion enabled, 0 = center frozen
//   key_grow   in   1   one-cycle request: radius += R_STEP
//   key_shrink in   1   one-cycle request: radius -= R_STEP
//   cx         out  10  circle center x
//   cy         out  10  circle center y
//   radius     out  10  circle radius
//   color      out  16  RGB565 fill color
//   upd_done   out  1   one-cycle pulse when new parameters are committed
//
// Handshake: there is no valid/ready pair here. key_grow/key_shrink are
// fire-and-forget pulses captured into sticky flags; upd_done is a pure
// notification pulse with no back-pressure.
// ---------------------------------------------------------------------------
module vga_circle_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int X0        = 320,
    parameter int Y0        = 240,
    parameter int R0        = 40,
    parameter int R_MIN     = 16,
    parameter int R_MAX     = 96,
    parameter int R_STEP    = 4,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        run,
    input  logic        key_grow,
    input  logic        key_shrink,
    output logic [9:0]  cx,
    output logic [9:0]  cy,
    output logic [9:0]  radius,
    output logic [15:0] color,
    output logic        upd_done
);

    localparam logic [7:0]         DIV_LAST = 8'(FRAME_DIV - 1);
    localparam logic [10:0]        R_MIN_W  = 11'(R_MIN);
    localparam logic [10:0]        R_MAX_W  = 11'(R_MAX);
    localparam logic [10:0]        R_STEP_W = 11'(R_STEP);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [10:0] H_LIM    = 11'(H_ACTIVE - 1);
    localparam logic signed [10:0] V_LIM    = 11'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC_R = 3'd1,
        CALC_X = 3'd2,
        CALC_Y = 3'd3,
        COMMIT = 3'd4
    } state_t;

    // Result of one axis step: new position, new direction, bounce flag.
    typedef struct packed {
        logic signed [10:0] pos;
        logic               neg;
        logic               bounce;
    } axis_t;

    state_t             state;
    logic               vs_q;
    logic               trig;
    logic [7:0]         div_cnt;
    logic               pend_grow;
    logic               pend_shrink;
    logic               dx_neg;
    logic               dy_neg;
    logic [2:0]         pal_idx;

    // Shadow values, only visible on the outputs after COMMIT.
    logic [10:0]        r_n;
    logic signed [10:0] x_n;
    logic signed [10:0] y_n;
    logic               dx_n_neg;
    logic               dy_n_neg;
    logic               bounce_x;
    logic               bounce_y;

    logic [10:0]        r_cur;
    logic [10:0]        r_grow;
    logic [10:0]        r_shrink;
    logic [10:0]        r_calc;
    axis_t              ax;
    axis_t              ay;

    function automatic logic [15:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 16'hF800;
            3'd1:    palette = 16'hFFE0;
            3'd2:    palette = 16'h07E0;
            3'd3:    palette = 16'h07FF;
            3'd4:    palette = 16'h001F;
            3'd5:    palette = 16'hF81F;
            3'd6:    palette = 16'hFFFF;
            default: palette = 16'hFD20;
        endcase
    endfunction

    // One axis update: move by STEP in the current direction; if the circle
    // would cross a wall, clamp it against that wall and reverse. The clamp
    // also pulls back a circle that grew past the wall.
    function automatic axis_t axis_step(input logic [9:0]         pos,
                                        input logic               neg,
                                        input logic [10:0]        r,
                                        input logic signed [10:0] lim,
                                        input logic               en);
        axis_t              res;
        logic signed [10:0] p;
        logic signed [10:0] rs;
        logic signed [10:0] t;
        p          = signed'({1'b0, pos});
        rs         = signed'(r);
        t          = p;
        res.pos    = p;
        res.neg    = neg;
        res.bounce = 1'b0;
        if (en) begin
            if (!neg) begin
                t = p + STEP_S;
                if (t + rs > lim) begin
                    res.pos    = lim - rs;
                    res.neg    = 1'b1;
                    res.bounce = 1'b1;
                end else begin
                    res.pos = t;
                end
            end else begin
                t = p - STEP_S;
                if (t < rs) begin
                    res.pos    = rs;
                    res.neg    = 1'b0;
                    res.bounce = 1'b1;
                end else begin
                    res.pos = t;
                end
            end
        end
        return res;
    endfunction

    assign trig = vsync & ~vs_q;

    always_comb begin
        r_cur    = {1'b0, radius};
        r_grow   = r_cur + R_STEP_W;
        r_shrink = r_cur - R_STEP_W;
        r_calc   = r_cur;
        // Simultaneous grow and shrink cancel out.
        if (pend_grow && !pend_shrink) begin
            r_calc = (r_grow > R_MAX_W) ? R_MAX_W : r_grow;
        end else if (pend_shrink && !pend_grow) begin
            // Compare before subtracting so a small radius cannot wrap.
            r_calc = (r_cur < R_MIN_W + R_STEP_W) ? R_MIN_W : r_shrink;
        end
    end

    assign ax = axis_step(cx, dx_neg, r_n, H_LIM, run);
    assign ay = axis_step(cy, dy_neg, r_n, V_LIM, run);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            vs_q        <= 1'b1;  // vsync already high at release is not an edge
            div_cnt     <= 8'd0;
            pend_grow   <= 1'b0;
            pend_shrink <= 1'b0;
            dx_neg      <= 1'b0;
            dy_neg      <= 1'b0;
            pal_idx     <= 3'd0;
            r_n         <= 11'(R0);
            x_n         <= 11'(X0);
            y_n         <= 11'(Y0);
            dx_n_neg    <= 1'b0;
            dy_n_neg    <= 1'b0;
            bounce_x    <= 1'b0;
            bounce_y    <= 1'b0;
            cx          <= 10'(X0);
            cy          <= 10'(Y0);
            radius      <= 10'(R0);
            color       <= 16'hF800;
            upd_done    <= 1'b0;
        end else begin
            vs_q        <= vsync;
            upd_done    <= 1'b0;
            pend_grow   <= pend_grow | key_grow;
            pend_shrink <= pend_shrink | key_shrink;

            case (state)
                IDLE: begin
                    if (trig) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= 8'd0;
                            state   <= CALC_R;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end
                CALC_R: begin
                    r_n         <= r_calc;
                    // Consume pending requests; a pulse in this very cycle
                    // survives for the next update.
                    pend_grow   <= key_grow;
                    pend_shrink <= key_shrink;
                    state       <= CALC_X;
                end
                CALC_X: begin
                    x_n      <= ax.pos;
                    dx_n_neg <= ax.neg;
                    bounce_x <= ax.bounce;
                    state    <= CALC_Y;
                end
                CALC_Y: begin
                    y_n      <= ay.pos;
                    dy_n_neg <= ay.neg;
                    bounce_y <= ay.bounce;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    cx       <= x_n[9:0];
                    cy       <= y_n[9:0];
                    radius   <= r_n[9:0];
                    dx_neg   <= dx_n_neg;
                    dy_neg   <= dy_n_neg;
                    // A corner hit still advances the palette only once.
                    if (bounce_x || bounce_y) begin
                        pal_idx <= pal_idx + 3'd1;
                        color   <= palette(pal_idx + 3'd1);
                    end
                    upd_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
